usb_link_fsm: RTL and testbench

// - Parametrised link-layer transaction sequencer for the half-duplex USB-style link.
// - Tracks token -> data -> handshake for master and slave roles, and OUT/SETUP/IN tokens.
// - Drives bus direction with a programmable turnaround gap.
// - Times out missing responses and keeps per-endpoint DATA0/DATA1 toggles.
// - Sits between the crc5/crc16 rx/tx framers and control_t.

---
 rtl/usb_link_fsm.sv | 278 +++++++++++++++++++++++++++
 tb/tb_usb_link_fsm.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_link_fsm.sv
// usb_link_fsm
// Link-layer transaction sequencer for the half-duplex USB-style link.
// Sequences token -> data -> handshake in both master and slave roles, drives
// the bus direction with a programmable turnaround gap, times out missing
// responses and keeps a DATA0/DATA1 toggle per endpoint.
//
// Optional build macro: USB_LINK_RETRY_EN
//   When defined, master-role failures (timeout or NAK) are absorbed silently
//   up to MAX_RETRY times so upstream can re-issue the token; the next failure
//   reports xfer_done and clears the count.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a token (tx token as master, rx token as slave)
// TOK     | master sending its token, waiting for tx eop
// TURN    | bus turnaround gap of delay_threshold+1 cycles, then turn_nxt
// TX_DATA | sending a data packet
// RX_DATA | receiving a data packet; response timer runs until rx sop
// TX_HS   | sending a handshake
// RX_HS   | waiting for a handshake; response timer runs
module usb_link_fsm #(
    parameter int TIMER_W   = 16,
    parameter int DELAY_W   = 6,
    parameter int NUM_EP    = 4,
    parameter int MAX_RETRY = 3,
    localparam int EP_W     = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ms,
    input  logic [TIMER_W-1:0] time_threshold,
    input  logic [DELAY_W-1:0] delay_threshold,
    input  logic [EP_W-1:0]    ep_sel,
    input  logic               rx_pid_en,
    input  logic [3:0]         rx_pid,
    input  logic               rx_sop_en,
    input  logic               rx_lt_eop_en,
    input  logic               tx_con_pid_en,
    input  logic [3:0]         tx_con_pid,
    input  logic               tx_lp_eop_en,
    output logic               rx_data_on,
    output logic               rx_handshake_on,
    output logic               tx_data_on,
    output logic               tx_hs_on,
    output logic [3:0]         data_pid,
    output logic               d_oe,
    output logic               time_out,
    output logic               xfer_done,
    output logic [1:0]         hs_result
);

`ifdef USB_LINK_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [1:0] HS_NONE  = 2'd0;
    localparam logic [1:0] HS_ACK   = 2'd1;
    localparam logic [1:0] HS_NAK   = 2'd2;
    localparam logic [1:0] HS_STALL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_TOK, S_TURN, S_TX_DATA, S_RX_DATA, S_TX_HS, S_RX_HS
    } state_t;

    state_t             state;
    state_t             turn_nxt;
    logic               role;
    logic               is_in;
    logic               is_setup;
    logic [EP_W-1:0]    ep_reg;
    logic [NUM_EP-1:0]  toggle;
    logic [DELAY_W-1:0] turn_cnt;
    logic [TIMER_W-1:0] timer;
    logic               sop_seen;
    logic [3:0]         hs_tx;
    logic               quiet;
    logic [RC_W-1:0]    retry_cnt;

    logic [1:0]         rx_hs;
    logic [1:0]         tx_hs_code;
    logic [TIMER_W-1:0] timer_inc;
    logic               timer_run;
    logic               tmo_fire;
    logic               fail_quiet;

    function automatic logic [1:0] hs_code(input logic [3:0] pid);
        case (pid)
            PID_ACK:   return HS_ACK;
            PID_NAK:   return HS_NAK;
            PID_STALL: return HS_STALL;
            default:   return HS_NONE;
        endcase
    endfunction

    function automatic logic is_token(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP);
    endfunction

    assign rx_hs      = hs_code(rx_pid);
    assign tx_hs_code = hs_code(tx_con_pid_en ? tx_con_pid : hs_tx);
    assign timer_inc  = (timer == '1) ? timer : timer + TIMER_W'(1);
    // An arriving sop or valid handshake stops the timer in the same cycle,
    // so it always beats a coincident timeout.
    assign timer_run  = ((state == S_RX_DATA) && !sop_seen && !rx_sop_en) ||
                        ((state == S_RX_HS) && !(rx_pid_en && (rx_hs != HS_NONE)));
    assign tmo_fire   = timer_run && (time_threshold != '0) && (timer_inc == time_threshold);
    assign fail_quiet = RETRY_EN && role && (retry_cnt < RC_W'(MAX_RETRY));

    assign rx_data_on      = (state == S_RX_DATA);
    assign rx_handshake_on = (state == S_RX_HS);
    assign tx_data_on      = (state == S_TX_DATA);
    assign tx_hs_on        = (state == S_TX_HS);

    // Transaction sequencer, toggles, timers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            turn_nxt  <= S_IDLE;
            role      <= 1'b0;
            is_in     <= 1'b0;
            is_setup  <= 1'b0;
            ep_reg    <= '0;
            toggle    <= '0;
            turn_cnt  <= '0;
            timer     <= '0;
            sop_seen  <= 1'b0;
            hs_tx     <= '0;
            quiet     <= 1'b0;
            retry_cnt <= '0;
            d_oe      <= ms;
            time_out  <= 1'b0;
            xfer_done <= 1'b0;
            hs_result <= HS_NONE;
            data_pid  <= '0;
        end else begin
            time_out  <= 1'b0;
            xfer_done <= 1'b0;
            data_pid  <= toggle[ep_sel] ? PID_DATA1 : PID_DATA0;
            if (timer_run) timer <= timer_inc;

            if (tmo_fire) begin
                state     <= S_IDLE;
                d_oe      <= ms;
                time_out  <= 1'b1;
                hs_result <= HS_NONE;
                xfer_done <= !fail_quiet;
                if (RETRY_EN) retry_cnt <= fail_quiet ? retry_cnt + RC_W'(1) : '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        role  <= ms;
                        d_oe  <= ms;
                        quiet <= 1'b0;
                        if (ms) begin
                            if (tx_con_pid_en && is_token(tx_con_pid)) begin
                                is_in    <= (tx_con_pid == PID_IN);
                                is_setup <= (tx_con_pid == PID_SETUP);
                                ep_reg   <= ep_sel;
                                state    <= S_TOK;
                            end
                        end else if (rx_pid_en && is_token(rx_pid)) begin
                            is_in    <= (rx_pid == PID_IN);
                            is_setup <= (rx_pid == PID_SETUP);
                            ep_reg   <= ep_sel;
                            if (rx_pid == PID_IN) begin
                                state    <= S_TURN;
                                turn_nxt <= S_TX_DATA;
                                turn_cnt <= '0;
                            end else begin
                                state    <= S_RX_DATA;
                                timer    <= '0;
                                sop_seen <= 1'b0;
                            end
                        end
                    end
                    S_TOK: begin
                        if (tx_lp_eop_en) begin
                            if (is_in) begin
                                state    <= S_TURN;
                                turn_nxt <= S_RX_DATA;
                                turn_cnt <= '0;
                            end else begin
                                state <= S_TX_DATA;
                            end
                        end
                    end
                    S_TX_DATA: begin
                        if (tx_lp_eop_en) begin
                            state    <= S_TURN;
                            turn_nxt <= S_RX_HS;
                            turn_cnt <= '0;
                        end
                    end
                    S_TURN: begin
                        if (turn_cnt == delay_threshold) begin
                            state    <= turn_nxt;
                            timer    <= '0;
                            sop_seen <= 1'b0;
                            hs_tx    <= '0;
                            case (turn_nxt)
                                S_IDLE: begin
                                    d_oe      <= ms;
                                    xfer_done <= !quiet;
                                end
                                S_RX_DATA, S_RX_HS: d_oe <= 1'b0;
                                default:            d_oe <= 1'b1;
                            endcase
                        end else begin
                            turn_cnt <= turn_cnt + DELAY_W'(1);
                        end
                    end
                    S_RX_DATA: begin
                        if (rx_sop_en) sop_seen <= 1'b1;
                        if ((sop_seen || rx_sop_en) && rx_lt_eop_en) begin
                            state    <= S_TURN;
                            turn_nxt <= S_TX_HS;
                            turn_cnt <= '0;
                        end
                    end
                    S_TX_HS: begin
                        if (tx_con_pid_en) hs_tx <= tx_con_pid;
                        if (tx_lp_eop_en) begin
                            hs_result <= tx_hs_code;
                            if (tx_hs_code == HS_ACK) toggle[ep_reg] <= is_setup | ~toggle[ep_reg];
                            if (RETRY_EN && ((tx_hs_code == HS_ACK) || (tx_hs_code == HS_STALL)))
                                retry_cnt <= '0;
                            if (role) begin
                                state     <= S_IDLE;
                                d_oe      <= ms;
                                xfer_done <= 1'b1;
                            end else begin
                                state    <= S_TURN;
                                turn_nxt <= S_IDLE;
                                turn_cnt <= '0;
                                quiet    <= 1'b0;
                            end
                        end
                    end
                    S_RX_HS: begin
                        // Non-handshake PIDs are not responses and leave the wait running.
                        if (rx_pid_en && (rx_hs != HS_NONE)) begin
                            hs_result <= rx_hs;
                            if (rx_hs == HS_ACK) toggle[ep_reg] <= is_setup | ~toggle[ep_reg];
                            if (RETRY_EN)
                                retry_cnt <= ((rx_hs == HS_NAK) && fail_quiet) ?
                                             retry_cnt + RC_W'(1) : '0;
                            if (role) begin
                                state    <= S_TURN;
                                turn_nxt <= S_IDLE;
                                turn_cnt <= '0;
                                quiet    <= (rx_hs == HS_NAK) && fail_quiet;
                            end else begin
                                state     <= S_IDLE;
                                d_oe      <= ms;
                                xfer_done <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_link_fsm.sv
// tb_usb_link_fsm
// Directed bench for usb_link_fsm: master/slave OUT, IN, SETUP flows, turnaround
// gaps, timeouts, handshake-vs-timeout race, NAK handling and mid-transfer reset.
// Expected handshake results are queued when a transaction is launched and
// retired when the DUT signals xfer_done.
module tb_usb_link_fsm;

`ifdef USB_LINK_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] DATA0     = 4'b0011;
    localparam logic [3:0] DATA1     = 4'b1011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ms;
    logic [15:0] time_threshold;
    logic [5:0]  delay_threshold;
    logic [1:0]  ep_sel;
    logic        rx_pid_en;
    logic [3:0]  rx_pid;
    logic        rx_sop_en;
    logic        rx_lt_eop_en;
    logic        tx_con_pid_en;
    logic [3:0]  tx_con_pid;
    logic        tx_lp_eop_en;
    logic        rx_data_on;
    logic        rx_handshake_on;
    logic        tx_data_on;
    logic        tx_hs_on;
    logic [3:0]  data_pid;
    logic        d_oe;
    logic        time_out;
    logic        xfer_done;
    logic [1:0]  hs_result;

    int checks = 0;
    int errors = 0;
    logic [1:0] sb[$];

    usb_link_fsm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ms              (ms),
        .time_threshold  (time_threshold),
        .delay_threshold (delay_threshold),
        .ep_sel          (ep_sel),
        .rx_pid_en       (rx_pid_en),
        .rx_pid          (rx_pid),
        .rx_sop_en       (rx_sop_en),
        .rx_lt_eop_en    (rx_lt_eop_en),
        .tx_con_pid_en   (tx_con_pid_en),
        .tx_con_pid      (tx_con_pid),
        .tx_lp_eop_en    (tx_lp_eop_en),
        .rx_data_on      (rx_data_on),
        .rx_handshake_on (rx_handshake_on),
        .tx_data_on      (tx_data_on),
        .tx_hs_on        (tx_hs_on),
        .data_pid        (data_pid),
        .d_oe            (d_oe),
        .time_out        (time_out),
        .xfer_done       (xfer_done),
        .hs_result       (hs_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic retire();
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("hs_result", 32'(hs_result), 32'(sb.pop_front()));
    endtask

    task automatic wait_xfer(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (xfer_done === 1'b1) break;
            tick();
        end
        chk("xfer_done_seen", 32'(xfer_done), 1);
        if (xfer_done === 1'b1) retire();
    endtask

    task automatic tx_tok(input logic [3:0] pid, input logic [1:0] ep);
        tx_con_pid_en = 1'b1; tx_con_pid = pid; ep_sel = ep;
        tick();
        tx_con_pid_en = 1'b0;
    endtask

    task automatic tx_pid(input logic [3:0] pid);
        tx_con_pid_en = 1'b1; tx_con_pid = pid;
        tick();
        tx_con_pid_en = 1'b0;
    endtask

    task automatic tx_eop();
        tx_lp_eop_en = 1'b1;
        tick();
        tx_lp_eop_en = 1'b0;
    endtask

    task automatic rx_tok(input logic [3:0] pid, input logic [1:0] ep);
        rx_pid_en = 1'b1; rx_pid = pid; ep_sel = ep;
        tick();
        rx_pid_en = 1'b0;
    endtask

    task automatic rx_hs(input logic [3:0] pid);
        rx_pid_en = 1'b1; rx_pid = pid;
        tick();
        rx_pid_en = 1'b0;
    endtask

    task automatic ep_pid(input logic [1:0] ep, input logic [3:0] exp, input string tag);
        ep_sel = ep;
        tick();
        chk(tag, 32'(data_pid), 32'(exp));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; ms = 1'b1; time_threshold = '0; delay_threshold = '0; ep_sel = '0;
        rx_pid_en = 1'b0; rx_pid = '0; rx_sop_en = 1'b0; rx_lt_eop_en = 1'b0;
        tx_con_pid_en = 1'b0; tx_con_pid = '0; tx_lp_eop_en = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_d_oe", 32'(d_oe), 1);
        chk("rst_xfer_done", 32'(xfer_done), 0);
        chk("rst_hs_result", 32'(hs_result), 0);
        chk("rst_data_pid", 32'(data_pid), 0);
        chk("rst_enables", {rx_data_on, rx_handshake_on, tx_data_on, tx_hs_on, time_out}, 0);
        rst_n = 1'b1;
        ep_pid(2'd1, DATA0, "post_rst_data_pid");

        // Master OUT ep1, 4-cycle turnaround, ACK after 10 cycles
        delay_threshold = 6'd3; time_threshold = 16'd100;
        sb.push_back(2'd1);
        tx_tok(PID_OUT, 2'd1);
        chk("mout_tok_d_oe", 32'(d_oe), 1);
        tx_eop();
        chk("mout_tx_data_on", 32'(tx_data_on), 1);
        tx_eop();
        chk("mout_turn_tx_off", 32'(tx_data_on), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("mout_gap_d_oe_hold", 32'(d_oe), 1);
        tick();
        chk("mout_gap_d_oe_rx", 32'(d_oe), 0);
        chk("mout_rx_hs_on", 32'(rx_handshake_on), 1);
        for (int i = 0; i < 9; i++) tick();
        rx_hs(PID_ACK);
        chk("mout_hs_off", 32'(rx_handshake_on), 0);
        wait_xfer(20);
        chk("mout_end_d_oe", 32'(d_oe), 1);
        ep_pid(2'd1, DATA1, "mout_toggle_ep1");
        ep_pid(2'd0, DATA0, "mout_toggle_ep0");

        // Master IN ep0, no device reply: timeout 20 cycles after RX_DATA entry
        delay_threshold = 6'd0; time_threshold = 16'd20;
        if (!RETRY) sb.push_back(2'd0);
        tx_tok(PID_IN, 2'd0);
        tx_eop();
        tick();
        chk("min_rx_data_on", 32'(rx_data_on), 1);
        chk("min_d_oe_rx", 32'(d_oe), 0);
        n = 0;
        while (time_out !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("min_tmo_latency", 32'(n), 20);
        chk("min_tmo_idle", 32'(rx_data_on), 0);
        chk("min_tmo_d_oe", 32'(d_oe), 1);
        chk("min_tmo_done", 32'(xfer_done), RETRY ? 0 : 1);
        if (xfer_done === 1'b1) retire();
        tick();
        chk("min_tmo_pulse", 32'(time_out), 0);

        // Master SETUP ep1: ACK arrives on the same cycle the timer expires
        time_threshold = 16'd5;
        sb.push_back(2'd1);
        tx_tok(PID_SETUP, 2'd1);
        tx_eop();
        tx_eop();
        tick();
        chk("setup_rx_hs_on", 32'(rx_handshake_on), 1);
        for (int i = 0; i < 4; i++) tick();
        rx_hs(PID_ACK);
        chk("race_no_time_out", 32'(time_out), 0);
        wait_xfer(10);
        ep_pid(2'd1, DATA1, "setup_forces_data1");

        // Master OUT ep3, four NAKs
        time_threshold = 16'd0;
        for (int k = 0; k < 4; k++) begin
            if (!RETRY || k == 3) sb.push_back(2'd2);
            tx_tok(PID_OUT, 2'd3);
            tx_eop();
            tx_eop();
            tick();
            rx_hs(PID_NAK);
            tick();
            chk($sformatf("nak%0d_done", k), 32'(xfer_done), (!RETRY || k == 3) ? 1 : 0);
            if (xfer_done === 1'b1) retire();
            tick();
        end
        ep_pid(2'd3, DATA0, "nak_no_toggle");

        // Slave OUT ep2, 3-cycle turnaround
        ms = 1'b0; delay_threshold = 6'd2;
        tick();
        chk("slave_idle_d_oe", 32'(d_oe), 0);
        sb.push_back(2'd1);
        rx_tok(PID_OUT, 2'd2);
        chk("sout_rx_data_on", 32'(rx_data_on), 1);
        rx_sop_en = 1'b1; tick(); rx_sop_en = 1'b0;
        rx_lt_eop_en = 1'b1; tick(); rx_lt_eop_en = 1'b0;
        chk("sout_turn", 32'(rx_data_on), 0);
        tick(); tick();
        chk("sout_gap_d_oe_hold", 32'(d_oe), 0);
        tick();
        chk("sout_gap_d_oe_tx", 32'(d_oe), 1);
        chk("sout_tx_hs_on", 32'(tx_hs_on), 1);
        for (int i = 0; i < 3; i++) tick();
        tx_pid(PID_ACK);
        chk("sout_tx_hs_hold", 32'(tx_hs_on), 1);
        tx_eop();
        chk("sout_tx_hs_off", 32'(tx_hs_on), 0);
        wait_xfer(10);
        chk("sout_end_d_oe", 32'(d_oe), 0);
        ep_pid(2'd2, DATA1, "sout_toggle_ep2");

        // Slave IN ep0, host sends a stray non-handshake PID then ACK
        delay_threshold = 6'd1;
        sb.push_back(2'd1);
        rx_tok(PID_IN, 2'd0);
        tick(); tick();
        chk("sin_tx_data_on", 32'(tx_data_on), 1);
        chk("sin_d_oe_tx", 32'(d_oe), 1);
        tx_eop();
        tick(); tick();
        chk("sin_d_oe_rx", 32'(d_oe), 0);
        rx_hs(PID_OUT);
        chk("sin_ignore_non_hs", 32'(rx_handshake_on), 1);
        rx_hs(PID_ACK);
        chk("sin_done", 32'(xfer_done), 1);
        if (xfer_done === 1'b1) retire();
        ep_pid(2'd0, DATA1, "sin_toggle_ep0");

        // Reset while in TX_DATA
        ms = 1'b1;
        tick();
        tx_tok(PID_OUT, 2'd2);
        tx_eop();
        chk("rst_mid_tx_data_on", 32'(tx_data_on), 1);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_tx_off", 32'(tx_data_on), 0);
        chk("rst_mid_d_oe", 32'(d_oe), 1);
        chk("rst_mid_hs_result", 32'(hs_result), 0);
        rst_n = 1'b1;
        ep_pid(2'd2, DATA0, "rst_mid_toggle_ep2");
        ep_pid(2'd0, DATA0, "rst_mid_toggle_ep0");

        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
